// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one 16-bit UART transmitter
//               among N_REQ requesters. Optionally prepends a source-ID
//               header word, sequences tx_start/tx_done per word, and aborts
//               a transfer when the transmitter stalls past TIMEOUT_CYC.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int         N_REQ       = 4,
  parameter int         ID_W        = 2,
  parameter bit         SEND_HEADER = 1'b1,
  parameter logic [7:0] HDR_TAG     = 8'hA5,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [15:0]         tx_data,
  output logic                tx_start,
  input  logic                tx_done,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id,
  output logic                timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Watchdog counter just wide enough to hold TIMEOUT_CYC.
  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam bit              WD_ON   = (TIMEOUT_CYC != 0);

  logic [1:0]      state_q,       state_d;
  logic [ID_W-1:0] last_grant_q,  last_grant_d;
  logic [15:0]     payload_q,     payload_d;
  logic [15:0]     tx_data_q,     tx_data_d;
  logic            tx_start_q,    tx_start_d;
  logic [N_REQ-1:0] req_ready_q,  req_ready_d;
  logic            busy_q,        busy_d;
  logic [ID_W-1:0] grant_id_q,    grant_id_d;
  logic            timeout_err_q, timeout_err_d;
  logic [WD_W-1:0] wd_cnt_q,      wd_cnt_d;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [15:0]     pick_word;
  logic [15:0]     hdr_word;
  logic            in_xfer;
  logic            wd_expire;

  assign in_xfer   = (state_q == ST_HDR) || (state_q == ST_DATA);
  // Expiry is decided in the cycle whose increment would reach TIMEOUT_CYC;
  // a tx_done in that same cycle takes priority.
  assign wd_expire = WD_ON && in_xfer && !tx_done && (wd_cnt_q == WD_LAST);
  assign hdr_word  = {HDR_TAG, 8'(pick_idx)};

  // Round-robin pick: first pending requester after last_grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_found && req_valid[i] && (i == (int'(last_grant_q) + k) % N_REQ)) begin
          pick_found = 1'b1;
          pick_idx   = ID_W'(i);
        end
      end
    end
  end

  // Select the winning requester's word.
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        pick_word = req_data[16*i +: 16];
      end
    end
  end

  // State register and all datapath flops; everything holds while enable is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_W'(N_REQ - 1);
      payload_q     <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      payload_q     <= payload_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  // Next-state logic: IDLE -> (HDR ->) DATA -> IDLE, watchdog aborts to IDLE.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) state_d = SEND_HEADER ? ST_HDR : ST_DATA;
        end
        ST_HDR: begin
          if (tx_done)        state_d = ST_DATA;
          else if (wd_expire) state_d = ST_IDLE;
        end
        ST_DATA: begin
          if (tx_done || wd_expire) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath logic: grant capture, word sequencing, watchdog.
  always_comb begin
    last_grant_d  = last_grant_q;
    payload_d     = payload_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = tx_start_q;
    req_ready_d   = req_ready_q;
    busy_d        = busy_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = wd_cnt_q;
    if (enable) begin
      // Pulses last a single enabled cycle.
      tx_start_d    = 1'b0;
      req_ready_d   = '0;
      timeout_err_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            for (int i = 0; i < N_REQ; i++) begin
              req_ready_d[i] = (pick_idx == ID_W'(i));
            end
            grant_id_d   = pick_idx;
            last_grant_d = pick_idx;
            payload_d    = pick_word;
            busy_d       = 1'b1;
            tx_start_d   = 1'b1;
            tx_data_d    = SEND_HEADER ? hdr_word : pick_word;
            wd_cnt_d     = '0;
          end
        end
        ST_HDR, ST_DATA: begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
          if (tx_done) begin
            if (state_q == ST_HDR) begin
              tx_start_d = 1'b1;
              tx_data_d  = payload_q;
              wd_cnt_d   = '0;
            end else begin
              busy_d = 1'b0;
            end
          end else if (wd_expire) begin
            timeout_err_d = 1'b1;
            busy_d        = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = req_ready_q & {N_REQ{enable}};
  assign tx_start    = tx_start_q & enable;
  assign timeout_err = timeout_err_q & enable;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter. Instance
//               dut_h sends headers, dut_p sends payload only; both use a
//               20-cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;

  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  logic [3:0]  p_req_valid;
  logic [63:0] p_req_data;
  logic [3:0]  p_req_ready;
  logic [15:0] p_tx_data;
  logic        p_tx_start;
  logic        p_tx_done;
  logic        p_busy;
  logic [1:0]  p_grant_id;
  logic        p_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4), .ID_W(2), .SEND_HEADER(1'b1), .HDR_TAG(8'hA5), .TIMEOUT_CYC(20)
  ) dut_h (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(
    .N_REQ(4), .ID_W(2), .SEND_HEADER(1'b0), .HDR_TAG(8'hA5), .TIMEOUT_CYC(20)
  ) dut_p (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(p_req_valid), .req_data(p_req_data), .req_ready(p_req_ready),
    .tx_data(p_tx_data), .tx_start(p_tx_start), .tx_done(p_tx_done),
    .busy(p_busy), .grant_id(p_grant_id), .timeout_err(p_timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Wait (bounded) until dut_h shows tx_start.
  task automatic wait_start(input int bound);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("wait_start_in_time", 32'(n < bound), 1);
  endtask

  // One full header+payload transfer on dut_h, transmitter answering promptly.
  task automatic serve(input int g, input logic [15:0] word, input logic [3:0] drop);
    wait_start(40);
    check("grant_id", grant_id, g);
    check("req_ready_onehot", req_ready, 32'(1) << g);
    check("hdr_word", tx_data, {8'hA5, 8'(g)});
    req_valid = req_valid & ~drop;
    tick();
    check("req_ready_one_cycle", req_ready, 0);
    check("hdr_held", tx_data, {8'hA5, 8'(g)});
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("data_start", tx_start, 1);
    check("data_word", tx_data, word);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("busy_fall", busy, 0);
  endtask

  initial begin
    logic seen;
    reset       = 1'b0;
    enable      = 1'b1;
    req_valid   = 4'b0000;
    req_data    = {16'h3333, 16'h1234, 16'h1111, 16'h0F0F};
    tx_done     = 1'b0;
    p_req_valid = 4'b0000;
    p_req_data  = {16'hC3C3, 16'h2222, 16'hC1C1, 16'h0000};
    p_tx_done   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    tick();

    // Single request from requester 2
    req_valid = 4'b0100;
    serve(2, 16'h1234, 4'b0100);

    // All requesters valid after reset: strict rotation 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111;
    serve(0, 16'h0F0F, 4'b0000);
    serve(1, 16'h1111, 4'b0000);
    serve(2, 16'h1234, 4'b0000);
    serve(3, 16'h3333, 4'b0000);
    serve(0, 16'h0F0F, 4'b0000);
    req_valid = 4'b0000;

    // Watchdog: requester 0 never completes, requester 1 then gets the link
    do_reset();
    req_valid = 4'b0011;
    wait_start(10);
    check("to_grant0", grant_id, 0);
    req_valid = 4'b0010;
    repeat (19) tick();
    check("to_no_err_early", timeout_err, 0);
    check("to_busy_before", busy, 1);
    tick();
    check("to_err_at_20", timeout_err, 1);
    check("to_busy_dropped", busy, 0);
    tick();
    check("to_err_one_cycle", timeout_err, 0);
    check("to_next_start", tx_start, 1);
    check("to_next_grant", grant_id, 1);
    check("to_next_hdr", tx_data, 16'hA501);
    req_valid = 4'b0000;
    // tx_done in the expiry cycle wins: no error, payload follows
    repeat (19) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("coinc_no_err", timeout_err, 0);
    check("coinc_data_start", tx_start, 1);
    check("coinc_data_word", tx_data, 16'h1111);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("coinc_busy_fall", busy, 0);

    // Enable low for 10 cycles mid-DATA, with a stray tx_done inside the window
    req_valid = 4'b1000;
    wait_start(10);
    check("en_grant3", grant_id, 3);
    req_valid = 4'b0000;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("en_data_word", tx_data, 16'h3333);
    repeat (5) tick();
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | tx_start | timeout_err | (|req_ready);
      tx_done = (i == 4);
      tick();
    end
    tx_done = 1'b0;
    enable = 1'b1;
    check("en_no_pulses", seen, 0);
    check("en_busy_held", busy, 1);
    seen = 1'b0;
    repeat (13) begin
      tick();
      seen = seen | timeout_err;
    end
    check("en_counter_frozen", seen, 0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("en_busy_fall", busy, 0);
    check("en_no_err_end", timeout_err, 0);

    // Reset during HDR
    req_valid = 4'b0100;
    wait_start(10);
    check("rh_grant2", grant_id, 2);
    req_valid = 4'b1111;
    tick();
    reset = 1'b0;
    tick();
    check("rh_req_ready", req_ready, 0);
    check("rh_tx_start", tx_start, 0);
    check("rh_busy", busy, 0);
    check("rh_tx_data", tx_data, 0);
    check("rh_grant_id", grant_id, 0);
    check("rh_timeout_err", timeout_err, 0);
    reset = 1'b1;
    wait_start(10);
    check("rh_first_grant", grant_id, 0);
    check("rh_first_ready", req_ready, 4'b0001);
    req_valid = 4'b0000;
    do_reset();

    // Payload-only instance: requesters 1 and 3, next start at d+2
    p_req_valid = 4'b1010;
    tick();
    check("p_start1", p_tx_start, 1);
    check("p_grant1", p_grant_id, 1);
    check("p_word1", p_tx_data, 16'hC1C1);
    check("p_ready1", p_req_ready, 4'b0010);
    p_req_valid = 4'b1000;
    tick();
    check("p_single_start", p_tx_start, 0);
    check("p_word1_held", p_tx_data, 16'hC1C1);
    tick();
    p_tx_done = 1'b1; tick(); p_tx_done = 1'b0;
    check("p_no_start_d1", p_tx_start, 0);
    check("p_idle_d1", p_busy, 0);
    tick();
    check("p_start_d2", p_tx_start, 1);
    check("p_grant3", p_grant_id, 3);
    check("p_word3", p_tx_data, 16'hC3C3);
    p_req_valid = 4'b0000;
    p_tx_done = 1'b1; tick(); p_tx_done = 1'b0;
    check("p_busy_fall", p_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
